// File: rtl/i2c_master_top_if.sv
// Parallel request/response channel between core logic and the single-byte I2C master.
`timescale 1ns/1ps
interface i2c_master_top_if;
    logic       ena;
    logic       rw;
    logic [7:0] data_in;
    logic [6:0] address;
    logic       valid;
    logic [7:0] data_out;

    modport master (output ena, output rw, output data_in, output address,
                    input  valid, input  data_out);
    modport slave  (input  ena, input  rw, input  data_in, input  address,
                    output valid, output data_out);
endinterface

// File: rtl/i2c_master_top.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL and SDA are open-drain and only ever pulled low or released.
`timescale 1ns/1ps
module i2c_master_top #(
    parameter int QUARTER = 63
) (
    input  logic            clk,
    input  logic            rst_n,
    i2c_master_top_if.slave req,
    output wire             scl_out,
    inout  wire             i2c_sda
);
    localparam int            QW     = $clog2(QUARTER);
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WRITE    = 4'd4,
        ST_WACK     = 4'd5,
        ST_READ     = 4'd6,
        ST_RACK     = 4'd7,
        ST_STOP     = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdsh_q, rdsh_d;
    logic          samp_q, samp_d;
    logic          err_q, err_d;
    logic          free_q, free_d;
    logic          scl_low_q, scl_low_d;
    logic          sda_low_q, sda_low_d;
    logic          valid_q, valid_d;
    logic [7:0]    dout_q, dout_d;

    logic sda_in_s;
    logic q_last_s;
    logic bit_end_s;
    logic sample_s;

    assign sda_in_s  = i2c_sda;
    assign q_last_s  = (qcnt_q == Q_LAST);
    assign bit_end_s = q_last_s && (qtr_q == 2'd3);
    // Mid-high point of SCL: first cycle of the fourth quarter.
    assign sample_s  = (qtr_q == 2'd3) && (qcnt_q == '0);

    assign scl_out      = scl_low_q ? 1'b0 : 1'bz;
    assign i2c_sda      = sda_low_q ? 1'b0 : 1'bz;
    assign req.valid    = valid_q;
    assign req.data_out = dout_q;

    // State, timing counters, datapath and registered line drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdsh_q    <= 8'h00;
            samp_q    <= 1'b1;
            err_q     <= 1'b0;
            free_q    <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
            valid_q   <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdsh_q    <= rdsh_d;
            samp_q    <= samp_d;
            err_q     <= err_d;
            free_q    <= free_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            valid_q   <= valid_d;
            dout_q    <= dout_d;
        end
    end

    // Next-state, counter and datapath decode.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdsh_d  = rdsh_q;
        samp_d  = samp_q;
        err_d   = err_q;
        free_d  = free_q;
        valid_d = 1'b0;
        dout_d  = dout_q;
        qcnt_d  = q_last_s ? '0 : qcnt_q + QW'(1);
        qtr_d   = q_last_s ? qtr_q + 2'd1 : qtr_q;
        case (state_q)
            ST_IDLE: begin
                qcnt_d = '0;
                qtr_d  = 2'd0;
                if (req.ena) begin
                    state_d = ST_START;
                    addr_d  = {req.address, req.rw};
                    wdata_d = req.data_in;
                    err_d   = 1'b0;
                    free_d  = 1'b0;
                    bit_d   = 3'd7;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = bit_end_s ? ST_ADDR : ST_START;
            end
            ST_ADDR: begin
                if (bit_end_s) begin
                    bit_d   = bit_q - 3'd1;
                    state_d = (bit_q == 3'd0) ? ST_ADDR_ACK : ST_ADDR;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR_ACK: begin
                samp_d = sample_s ? sda_in_s : samp_q;
                if (bit_end_s) begin
                    if (samp_q) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = addr_q[0] ? ST_READ : ST_WRITE;
                    end
                end else begin
                    state_d = ST_ADDR_ACK;
                end
            end
            ST_WRITE: begin
                if (bit_end_s) begin
                    bit_d   = bit_q - 3'd1;
                    state_d = (bit_q == 3'd0) ? ST_WACK : ST_WRITE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WACK: begin
                samp_d = sample_s ? sda_in_s : samp_q;
                if (bit_end_s) begin
                    err_d   = samp_q;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_WACK;
                end
            end
            ST_READ: begin
                rdsh_d = sample_s ? {rdsh_q[6:0], sda_in_s} : rdsh_q;
                if (bit_end_s) begin
                    bit_d   = bit_q - 3'd1;
                    state_d = (bit_q == 3'd0) ? ST_RACK : ST_READ;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RACK: begin
                state_d = bit_end_s ? ST_STOP : ST_RACK;
            end
            ST_STOP: begin
                // Second pass through the four quarters is the bus-free gap.
                if (bit_end_s && free_q) begin
                    state_d = ST_IDLE;
                    free_d  = 1'b0;
                    valid_d = ~err_q;
                    dout_d  = (~err_q && addr_q[0]) ? rdsh_q : dout_q;
                end else if (bit_end_s) begin
                    free_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Open-drain pull-low requests per state and quarter.
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
            ST_START: begin
                sda_low_d = qtr_q[1];
            end
            ST_ADDR: begin
                scl_low_d = ~qtr_q[1];
                sda_low_d = ~addr_q[bit_q];
            end
            ST_WRITE: begin
                scl_low_d = ~qtr_q[1];
                sda_low_d = ~wdata_q[bit_q];
            end
            ST_ADDR_ACK, ST_WACK, ST_READ, ST_RACK: begin
                scl_low_d = ~qtr_q[1];
            end
            ST_STOP: begin
                scl_low_d = ~free_q & ~qtr_q[1];
                sda_low_d = ~free_q & (qtr_q != 2'd3);
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_i2c_master_top.sv
// Bench for i2c_master_top: bus-level slave/monitor plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_master_top;
    localparam int         Q       = 5;
    localparam int         BIT     = 4 * Q;
    localparam int         TXN_CYC = 24 * BIT;
    localparam logic [6:0] SLV     = 7'h10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic drive = 1'b0;
    wire  scl_w;
    wire  sda_w;

    pullup pu_scl (scl_w);
    pullup pu_sda (sda_w);
    assign sda_w = drive ? 1'b0 : 1'bz;

    i2c_master_top_if bus ();

    i2c_master_top #(.QUARTER(Q)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.slave),
        .scl_out (scl_w),
        .i2c_sda (sda_w)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_dout = 8'h00;
    logic [7:0] rdata = 8'h00;

    // Bus-side slave at address SLV and protocol monitor.
    int         cyc = 0;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       active = 1'b0, rd = 1'b0, hit = 1'b0, mack = 1'b0, hi_meas = 1'b0;
    int         bitn = 0, byte_idx = 0, hi_cnt = 0, bad_high = 0;
    int         starts = 0, stops = 0, start_cyc = 0, stop_cyc = 0, last_gap = 0;
    logic [7:0] sh = 8'h00, addr_byte = 8'h00, wr_byte = 8'h00;

    always @(negedge clk) begin
        cyc   <= cyc + 1;
        scl_p <= scl_w;
        sda_p <= sda_w;
        if (scl_p && scl_w && sda_p && !sda_w) begin
            starts    <= starts + 1;
            start_cyc <= cyc;
            last_gap  <= cyc - stop_cyc;
            active    <= 1'b1;
            bitn      <= -1;
            byte_idx  <= 0;
            sh        <= 8'h00;
            mack      <= 1'b0;
            hi_meas   <= 1'b0;
            drive     <= 1'b0;
        end else if (scl_p && scl_w && !sda_p && sda_w) begin
            stops    <= stops + 1;
            stop_cyc <= cyc;
            active   <= 1'b0;
            hi_meas  <= 1'b0;
            drive    <= 1'b0;
        end else if (!scl_p && scl_w) begin
            hi_meas <= 1'b1;
            hi_cnt  <= 1;
            if (active && bitn >= 0 && bitn < 8 && (byte_idx == 0 || !rd)) sh <= {sh[6:0], sda_w};
            if (active && bitn == 8 && byte_idx == 1 && rd) mack <= sda_w;
        end else if (scl_p && !scl_w) begin
            if (hi_meas && hi_cnt != 2 * Q) bad_high <= bad_high + 1;
            hi_meas <= 1'b0;
            if (active) begin
                if (bitn == 8) begin
                    bitn     <= 0;
                    byte_idx <= byte_idx + 1;
                    drive    <= (byte_idx == 0 && rd && hit) ? ~rdata[7] : 1'b0;
                end else begin
                    bitn <= bitn + 1;
                    if (bitn == 7 && byte_idx == 0) begin
                        addr_byte <= sh;
                        rd        <= sh[0];
                        hit       <= (sh[7:1] == SLV);
                        drive     <= (sh[7:1] == SLV);
                    end else if (bitn == 7 && byte_idx == 1 && !rd) begin
                        wr_byte <= sh;
                        drive   <= hit;
                    end else if (bitn >= 0 && bitn < 7 && byte_idx == 1 && rd && hit) begin
                        drive <= ~rdata[3'(6 - bitn)];
                    end else begin
                        drive <= 1'b0;
                    end
                end
            end
        end else if (scl_w && hi_meas) begin
            hi_cnt <= hi_cnt + 1;
        end
    end

    // Valid pulse monitor.
    int         valid_cnt = 0, valid_cyc = 0, wide = 0;
    logic       valid_p = 1'b0;
    logic [7:0] vout = 8'h00;

    always @(negedge clk) begin
        valid_p <= bus.valid;
        if (bus.valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
            vout      <= bus.data_out;
            if (valid_p) wide <= wide + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 4 * TXN_CYC; i++) begin
            if (starts >= n) break;
            @(negedge clk);
        end
        chk("start_seen", (starts >= n), 1);
    endtask

    task automatic wait_stops(input int n);
        for (int i = 0; i < 4 * TXN_CYC; i++) begin
            if (stops >= n) break;
            @(negedge clk);
        end
        chk("stop_seen", (stops >= n), 1);
    endtask

    // One isolated transaction; request inputs are scrambled while it runs.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d, input logic [7:0] rb);
        int   s0, p0, v0, lat;
        logic h;
        rdata = rb;
        s0 = starts;
        p0 = stops;
        v0 = valid_cnt;
        h  = (a == SLV);
        @(negedge clk);
        bus.ena = 1'b1; bus.address = a; bus.rw = r; bus.data_in = d;
        @(negedge clk);
        bus.ena = 1'b0; bus.address = 7'($urandom); bus.rw = 1'($urandom); bus.data_in = 8'($urandom);
        repeat (TXN_CYC) @(negedge clk);
        if (h && r) exp_dout = rb;
        lat = valid_cyc - start_cyc;
        chk("start_cnt", starts - s0, 1);
        chk("stop_cnt", stops - p0, 1);
        chk("addr_byte", addr_byte, {a, r});
        chk("valid_cnt", valid_cnt - v0, {31'd0, h});
        chk("data_out", bus.data_out, exp_dout);
        chk("scl_high_time", bad_high, 0);
        chk("valid_width", wide, 0);
        if (h) begin
            chk("valid_data", vout, exp_dout);
            chk("latency", (lat >= 82 * Q - 3 && lat <= 82 * Q + 1), 1);
            if (r) chk("master_nack", mack, 1'b1);
            else   chk("wr_byte", wr_byte, d);
        end
    endtask

    initial begin
        int         s0, p0, v0;
        logic [6:0] a;
        bus.ena = 1'b0; bus.rw = 1'b0; bus.address = 7'h00; bus.data_in = 8'h00;
        rst_n = 1'b0;
        #10 rst_n = 1'b1;
        #2;
        chk("rst_scl", scl_w, 1'b1);
        chk("rst_sda", sda_w, 1'b1);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_dout", bus.data_out, 8'h00);
        repeat (4) @(negedge clk);

        run_txn(7'h10, 1'b0, 8'h00, 8'h00);
        run_txn(7'h10, 1'b1, 8'h00, 8'hA5);
        run_txn(7'h55, 1'b0, 8'h3C, 8'h00);

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 3) != 0) a = SLV;
            else begin
                a = 7'($urandom);
                if (a == SLV) a = 7'h55;
            end
            run_txn(a, 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // Back-to-back: ena held high, inputs changed while the first runs.
        s0 = starts; p0 = stops; v0 = valid_cnt;
        rdata = 8'h3C;
        @(negedge clk);
        bus.ena = 1'b1; bus.address = SLV; bus.rw = 1'b0; bus.data_in = 8'h96;
        repeat (3 * BIT) @(negedge clk);
        bus.rw = 1'b1; bus.data_in = 8'h00;
        wait_stops(p0 + 1);
        chk("b2b_wr_byte", wr_byte, 8'h96);
        wait_starts(s0 + 2);
        bus.ena = 1'b0;
        chk("b2b_gap", (last_gap >= 4 * Q), 1);
        repeat (TXN_CYC) @(negedge clk);
        exp_dout = 8'h3C;
        chk("b2b_addr", addr_byte, {SLV, 1'b1});
        chk("b2b_dout", bus.data_out, exp_dout);
        chk("b2b_valid_cnt", valid_cnt - v0, 2);
        chk("b2b_start_cnt", starts - s0, 2);

        // Reset in the middle of the address phase.
        s0 = starts;
        @(negedge clk);
        bus.ena = 1'b1; bus.address = SLV; bus.rw = 1'b0; bus.data_in = 8'hFF;
        @(negedge clk);
        bus.ena = 1'b0;
        wait_starts(s0 + 1);
        repeat (3 * BIT + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_dout = 8'h00;
        chk("mid_rst_scl", scl_w, 1'b1);
        chk("mid_rst_sda", sda_w, 1'b1);
        chk("mid_rst_valid", bus.valid, 1'b0);
        chk("mid_rst_dout", bus.data_out, exp_dout);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        run_txn(SLV, 1'b1, 8'h00, 8'h5A);
        run_txn(SLV, 1'b0, 8'($urandom), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
